// File: rtl/mac_tile_seq_ctrl.sv
// Tile sequencer for a row-group of mode-switchable MAC units: weight-row load, accumulator
// clear, activation streaming with in-order response tracking, then psum drain to the output FIFO.
module mac_tile_seq_ctrl #(
    parameter int ROW    = 8,
    parameter int K_BW   = 8,
    parameter int OPC_BW = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   mode_2bit_in,
    input  logic [K_BW-1:0]        k_len,
    input  logic                   act_valid,
    input  logic                   ofifo_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   mode_2bit,
    output logic                   w_load_en,
    output logic [$clog2(ROW)-1:0] w_load_row,
    output logic                   acc_clr,
    output logic                   act_rd_en,
    output logic                   acc_en,
    output logic                   drain_en,
    output logic [$clog2(ROW)-1:0] drain_row,
    output logic [OPC_BW-1:0]      op_count,
    output logic [2:0]             dbg_state
);

    localparam int RW = $clog2(ROW);
    localparam logic [RW-1:0]   ROW_LAST = RW'(ROW - 1);
    localparam logic [OPC_BW:0] OPC_ONE  = (OPC_BW + 1)'(1);
    localparam logic [OPC_BW:0] OPC_TWO  = (OPC_BW + 1)'(2);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_W  = 3'd1,
        S_CLEAR   = 3'd2,
        S_COMPUTE = 3'd3,
        S_DRAIN   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t            state_q;
    logic              mode_q;
    logic [K_BW-1:0]   k_len_q;
    logic [RW-1:0]     row_q;
    logic [K_BW-1:0]   iss_q;
    logic [K_BW-1:0]   acc_q;
    logic [OPC_BW-1:0] opc_q;

    logic [RW-1:0]     row_d;
    logic [K_BW-1:0]   iss_d;
    logic [K_BW-1:0]   acc_d;
    logic [OPC_BW:0]   opc_sum;
    logic [OPC_BW-1:0] opc_d;

    // Handshakes: act_rd_en is a request counted by iss_q; each act_valid answers the oldest
    // outstanding request (in order, any latency, possibly the same cycle) and is counted by
    // acc_q. A psum row moves to the FIFO exactly in a cycle where drain_en is high.
    always_comb begin
        row_d   = row_q + 1'b1;
        iss_d   = iss_q + 1'b1;
        acc_d   = acc_q + 1'b1;
        opc_sum = {1'b0, opc_q} + (mode_q ? OPC_TWO : OPC_ONE);
        opc_d   = opc_sum[OPC_BW] ? {OPC_BW{1'b1}} : opc_sum[OPC_BW-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            k_len_q <= '0;
            row_q   <= '0;
            iss_q   <= '0;
            acc_q   <= '0;
            opc_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_q  <= mode_2bit_in;
                        k_len_q <= k_len;
                        opc_q   <= '0;
                        row_q   <= '0;
                        iss_q   <= '0;
                        acc_q   <= '0;
                        state_q <= (k_len == '0) ? S_DONE : S_LOAD_W;
                    end
                end
                S_LOAD_W: begin
                    if (row_q == ROW_LAST) begin
                        row_q   <= '0;
                        state_q <= S_CLEAR;
                    end else begin
                        row_q <= row_d;
                    end
                end
                S_CLEAR: begin
                    iss_q   <= '0;
                    acc_q   <= '0;
                    state_q <= S_COMPUTE;
                end
                S_COMPUTE: begin
                    if (iss_q < k_len_q) begin
                        iss_q <= iss_d;
                    end
                    if (act_valid) begin
                        acc_q <= acc_d;
                        opc_q <= opc_d;
                        if (acc_d == k_len_q) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (ofifo_ready) begin
                        if (row_q == ROW_LAST) begin
                            row_q   <= '0;
                            state_q <= S_DONE;
                        end else begin
                            row_q <= row_d;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode only registered state; acc_en/drain_en additionally pass the live handshake input.
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign mode_2bit  = mode_q;
    assign w_load_en  = (state_q == S_LOAD_W);
    assign w_load_row = (state_q == S_LOAD_W) ? row_q : '0;
    assign acc_clr    = (state_q == S_CLEAR);
    assign act_rd_en  = (state_q == S_COMPUTE) && (iss_q < k_len_q);
    assign acc_en     = (state_q == S_COMPUTE) && act_valid;
    assign drain_en   = (state_q == S_DRAIN) && ofifo_ready;
    assign drain_row  = (state_q == S_DRAIN) ? row_q : '0;
    assign op_count   = opc_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mac_tile_seq_ctrl.sv
// Bench for mac_tile_seq_ctrl: a per-tile event-timeline model predicts every output cycle by cycle
// from the tile rules, under random activation latency, FIFO backpressure and ignored inputs.
module tb_mac_tile_seq_ctrl;

    localparam int ROW    = 8;
    localparam int K_BW   = 8;
    localparam int OPC_BW = 32;
    localparam int MAXC   = 1024;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              mode_2bit_in = 1'b0;
    logic [K_BW-1:0]   k_len = '0;
    logic              act_valid = 1'b0;
    logic              ofifo_ready = 1'b1;
    logic              busy, done, mode_2bit, w_load_en, acc_clr, act_rd_en, acc_en, drain_en;
    logic [2:0]        w_load_row, drain_row;
    logic [OPC_BW-1:0] op_count;
    logic [2:0]        dbg_state;

    mac_tile_seq_ctrl #(.ROW(ROW), .K_BW(K_BW), .OPC_BW(OPC_BW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode_2bit_in(mode_2bit_in),
        .k_len(k_len), .act_valid(act_valid), .ofifo_ready(ofifo_ready),
        .busy(busy), .done(done), .mode_2bit(mode_2bit), .w_load_en(w_load_en),
        .w_load_row(w_load_row), .acc_clr(acc_clr), .act_rd_en(act_rd_en), .acc_en(acc_en),
        .drain_en(drain_en), .drain_row(drain_row), .op_count(op_count), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit busy; bit done; bit wle; int wrow; bit clr; bit rd; bit acc; bit drn; int drow;
        bit mode; int op;
    } exp_t;

    exp_t              exp_a [MAXC];
    bit                s_valid [MAXC];
    bit                s_ready [MAXC];
    bit                s_start [MAXC];
    bit                s_mode [MAXC];
    int                s_k [MAXC];
    logic [OPC_BW-1:0] exp_q[$];
    int                n_cmp = 0;
    int                n_fail = 0;
    int                cur_c = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] e);
        n_cmp++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cur_c, obs, e);
        end
    endtask

    // Builds the expected timeline of one tile, then starts it and compares every cycle.
    task automatic run_tile(input int k, input bit m, input int lat_fix, input int st_lo,
                            input int st_hi, input int stop_c, input bit noise,
                            output int done_obs);
        int last_c, prev, v, lat, row, c, d, op, inc;
        for (int i = 0; i < MAXC; i++) begin
            exp_a[i] = '{default: 0};
            exp_a[i].busy = 1'b1;
            exp_a[i].mode = m;
            s_valid[i] = noise ? bit'($urandom_range(0, 1)) : 1'b0;
            if (st_lo < 0) s_ready[i] = ($urandom_range(0, 3) != 0);
            else s_ready[i] = !(i >= st_lo && i <= st_hi);
            s_start[i] = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
            s_mode[i] = bit'($urandom_range(0, 1));
            s_k[i] = $urandom_range(0, 255);
        end
        inc = m ? 2 : 1;
        if (k == 0) begin
            exp_a[1].done = 1'b1;
            last_c = 1;
        end else begin
            for (int r = 0; r < ROW; r++) begin
                exp_a[1 + r].wle = 1'b1;
                exp_a[1 + r].wrow = r;
            end
            exp_a[ROW + 1].clr = 1'b1;
            prev = ROW + 1;
            for (int i = 0; i < k; i++) begin
                exp_a[ROW + 2 + i].rd = 1'b1;
                s_valid[ROW + 2 + i] = 1'b0;
            end
            for (int i = 0; i < k; i++) begin
                lat = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
                v = ROW + 2 + i + lat;
                if (v <= prev) v = prev + 1;
                for (int j = prev + 1; j < v; j++) s_valid[j] = 1'b0;
                s_valid[v] = 1'b1;
                exp_a[v].acc = 1'b1;
                prev = v;
            end
            d = prev + 1;
            row = 0;
            c = d;
            while (row < ROW) begin
                if (c - d > 40) s_ready[c] = 1'b1;
                exp_a[c].drn = s_ready[c];
                exp_a[c].drow = row;
                if (s_ready[c]) row++;
                c++;
            end
            exp_a[c].done = 1'b1;
            last_c = c;
        end
        op = 0;
        for (int i = 1; i <= last_c + 1; i++) begin
            exp_a[i].op = op;
            if (exp_a[i].acc) op += inc;
        end
        exp_a[last_c + 1].busy = 1'b0;
        s_start[last_c + 1] = 1'b0;
        if (stop_c == 0) exp_q.push_back(OPC_BW'(op));

        @(posedge clk); #1;
        start = 1'b1; mode_2bit_in = m; k_len = K_BW'(k);
        act_valid = noise ? bit'($urandom_range(0, 1)) : 1'b0; ofifo_ready = 1'b1;
        done_obs = -1;
        for (c = 1; c <= last_c + 1; c++) begin
            if (stop_c > 0 && c > stop_c) break;
            @(posedge clk); #1;
            start = s_start[c]; mode_2bit_in = s_mode[c]; k_len = K_BW'(s_k[c]);
            act_valid = s_valid[c]; ofifo_ready = s_ready[c];
            @(negedge clk);
            cur_c = c;
            check("busy", busy, exp_a[c].busy);
            check("done", done, exp_a[c].done);
            check("mode_2bit", mode_2bit, exp_a[c].mode);
            check("w_load_en", w_load_en, exp_a[c].wle);
            check("w_load_row", w_load_row, exp_a[c].wrow);
            check("acc_clr", acc_clr, exp_a[c].clr);
            check("act_rd_en", act_rd_en, exp_a[c].rd);
            check("acc_en", acc_en, exp_a[c].acc);
            check("drain_en", drain_en, exp_a[c].drn);
            check("drain_row", drain_row, exp_a[c].drow);
            check("op_count", op_count, exp_a[c].op);
            if (done === 1'b1 && done_obs < 0) done_obs = c;
            if (c == last_c + 1 && exp_q.size() > 0) check("sb_op_final", op_count, exp_q.pop_front());
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_mode"}, mode_2bit, 0);
        check({tag, "_wle"}, w_load_en, 0);
        check({tag, "_clr"}, acc_clr, 0);
        check({tag, "_rd"}, act_rd_en, 0);
        check({tag, "_acc"}, acc_en, 0);
        check({tag, "_drn"}, drain_en, 0);
        check({tag, "_op"}, op_count, 0);
    endtask

    initial begin
        int d;
        repeat (3) @(posedge clk);
        #2 act_valid = 1'b1;
        @(negedge clk);
        check_all_zero("reset");
        act_valid = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        run_tile(4, 1'b0, 0, 0, -1, 0, 1'b0, d);
        check("t1_done_cycle", d, 22);
        check("t1_op", op_count, 4);
        run_tile(4, 1'b1, 0, 0, -1, 0, 1'b0, d);
        check("t2_done_cycle", d, 22);
        check("t2_op", op_count, 8);
        run_tile(0, 1'b0, 0, 0, -1, 0, 1'b0, d);
        check("t3_done_cycle", d, 1);
        check("t3_op", op_count, 0);
        run_tile(2, 1'b0, 3, 0, -1, 0, 1'b0, d);
        check("t4_done_cycle", d, 23);
        run_tile(4, 1'b0, 0, 16, 18, 0, 1'b0, d);
        check("t5_done_cycle", d, 25);
        run_tile(255, 1'b1, -1, -1, 0, 0, 1'b1, d);
        check("kmax_op", op_count, 510);

        for (int t = 0; t < 25; t++) begin
            int k;
            k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(1, 30));
            run_tile(k, bit'($urandom_range(0, 1)), -1, -1, 0, 0, 1'b1, d);
        end

        run_tile(20, 1'b1, -1, -1, 0, 12, 1'b1, d);
        @(posedge clk); #2;
        start = 1'b1; act_valid = 1'b1; mode_2bit_in = 1'b0; k_len = 8'd5; reset_n = 1'b0;
        #1;
        cur_c = -1;
        check_all_zero("async_rst");
        @(negedge clk);
        check_all_zero("rst_hold");
        @(negedge clk);
        reset_n = 1'b1; start = 1'b0; act_valid = 1'b0;
        @(negedge clk);
        check_all_zero("post_rst");

        run_tile(3, 1'b1, -1, -1, 0, 0, 1'b1, d);
        check("post_rst_op", op_count, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
